// File: rtl/mem_arbiter_pkg.sv
// Shared widths, arbiter state encoding and watchdog default for mem_arbiter.
package mem_arbiter_pkg;

  localparam int unsigned REG_BUS             = 32;
  localparam int unsigned INST_ADDR_BUS       = 32;
  localparam int unsigned INST_BUS            = 32;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester single-port bus arbiter (data over fetch) with ack watchdog
// and pipeline stall request.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_ce_i,
  input  logic [INST_ADDR_BUS-1:0] if_addr_i,
  output logic [INST_BUS-1:0]      if_data_o,
  output logic                     if_ready_o,
  input  logic                     d_ce_i,
  input  logic                     d_we_i,
  input  logic [3:0]               d_sel_i,
  input  logic [REG_BUS-1:0]       d_addr_i,
  input  logic [REG_BUS-1:0]       d_wdata_i,
  output logic [REG_BUS-1:0]       d_rdata_o,
  output logic                     d_ready_o,
  output logic                     bus_req_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_sel_o,
  output logic [REG_BUS-1:0]       bus_addr_o,
  output logic [REG_BUS-1:0]       bus_wdata_o,
  input  logic [REG_BUS-1:0]       bus_rdata_i,
  input  logic                     bus_ack_i,
  output logic                     bus_err_o,
  output logic                     stallreq_o
);

  arb_state_t  state;
  logic [31:0] cnt;
  logic        timeout;

  assign timeout    = (cnt + 32'd1) == 32'(MEM_TIMEOUT);
  assign stallreq_o = (d_ce_i & ~d_ready_o) | (if_ce_i & ~if_ready_o);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_data_o   <= '0;
      if_ready_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_ready_o   <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      if_ready_o <= 1'b0;
      d_ready_o  <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          // A requester whose ready pulse is still high has its old request
          // on the wire; masking it here avoids a duplicate grant.
          if (d_ce_i && !d_ready_o) begin
            state       <= ARB_BUSY_D;
            cnt         <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= d_we_i;
            bus_sel_o   <= d_sel_i;
            bus_addr_o  <= d_addr_i;
            bus_wdata_o <= d_wdata_i;
          end else if (if_ce_i && !if_ready_o) begin
            state       <= ARB_BUSY_I;
            cnt         <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b1111;
            bus_addr_o  <= if_addr_i;
          end
        end
        ARB_BUSY_D: begin
          if (bus_ack_i) begin
            state     <= ARB_IDLE;
            bus_req_o <= 1'b0;
            d_ready_o <= 1'b1;
            if (!bus_we_o) d_rdata_o <= bus_rdata_i;
          end else if (timeout) begin
            state     <= ARB_IDLE;
            bus_req_o <= 1'b0;
            d_ready_o <= 1'b1;
            bus_err_o <= 1'b1;
            if (!bus_we_o) d_rdata_o <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ARB_BUSY_I: begin
          if (bus_ack_i) begin
            state      <= ARB_IDLE;
            bus_req_o  <= 1'b0;
            if_ready_o <= 1'b1;
            if_data_o  <= bus_rdata_i;
          end else if (timeout) begin
            state      <= ARB_IDLE;
            bus_req_o  <= 1'b0;
            if_ready_o <= 1'b1;
            bus_err_o  <= 1'b1;
            if_data_o  <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
